// File: rtl/ysyx_22041071_ifu_if.sv
// AXI read-channel bundle between the instruction fetch unit and memory.
interface ysyx_22041071_ifu_if;
    logic        ar_valid;
    logic [63:0] ar_addr;
    logic        ar_ready;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_ready;

    modport master (
        output ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/ysyx_22041071_ifu.sv
// Instruction fetch unit: one AXI read per instruction, 4-state FSM,
// redirect handling with a kill flag for in-flight fetches.
module ysyx_22041071_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_pc,
    ysyx_22041071_ifu_if.master        axi,
    output logic [63:0]                pc_out,
    output logic [31:0]                ins_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       fetch_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [63:0] addr_q;
    logic        kill, kill_nxt;
    logic        capture;
    logic        load_addr;
    logic [63:0] redir_tgt;

    // Redirect targets are word aligned; low two bits are dropped.
    assign redir_tgt = redirect_pc & ~64'd3;

    // A new address is latched only when entering ADDR, so redirects that
    // arrive while ar_valid is up never disturb the presented address.
    assign load_addr = (state_nxt == ADDR) && (state != ADDR);

    assign axi.ar_valid = (state == ADDR);
    assign axi.ar_addr  = addr_q;
    assign axi.r_ready  = (state == DATA);
    assign valid_out    = (state == HOLD);

    // Next-state, next-pc and kill-flag decisions.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = ADDR;
                if (redirect_valid) pc_nxt = redir_tgt;
            end
            ADDR: begin
                if (redirect_valid) begin
                    pc_nxt   = redir_tgt;
                    kill_nxt = 1'b1;
                end
                if (axi.ar_ready) state_nxt = DATA;
            end
            DATA: begin
                if (redirect_valid) begin
                    pc_nxt   = redir_tgt;
                    kill_nxt = 1'b1;
                end
                if (axi.r_valid) begin
                    // Data fetched for a superseded pc is dropped; a redirect
                    // landing on the return cycle makes it stale as well.
                    if (kill || redirect_valid) begin
                        state_nxt = ADDR;
                        kill_nxt  = 1'b0;
                    end else begin
                        state_nxt = HOLD;
                        capture   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redir_tgt;
                    state_nxt = ADDR;
                end else if (ready_in) begin
                    pc_nxt    = pc + 64'd4;
                    state_nxt = ADDR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pc, fetch address and the instruction holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            addr_q    <= RESET_PC;
            pc_out    <= RESET_PC;
            ins_out   <= 32'h0;
            fetch_err <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            if (load_addr) addr_q <= {pc_nxt[63:3], 3'b000};
            if (capture) begin
                pc_out    <= pc;
                ins_out   <= pc[2] ? axi.r_data[63:32] : axi.r_data[31:0];
                fetch_err <= (axi.r_resp != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_ifu.sv
// Bench for the fetch unit: directed vector table, hand sequences for
// redirect/stall/error/reset corners, then randomized traffic against a
// program-order model of the delivered instruction stream.
module tb_ysyx_22041071_ifu;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] pc_out;
    logic [31:0] ins_out;
    logic        valid_out;
    logic        ready_in;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    ysyx_22041071_ifu_if axi();

    ysyx_22041071_ifu dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .axi            (axi.master),
        .pc_out         (pc_out),
        .ins_out        (ins_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ar_ready;
        logic        r_valid;
        logic [63:0] r_data;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        e_arv;
        logic [63:0] e_addr;
        logic        e_rr;
        logic        e_v;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    function automatic vec_t mk(logic arr, logic rvl, logic [63:0] rd, logic rdy,
                                logic redv, logic [63:0] rpc, logic earv,
                                logic [63:0] eaddr, logic err_, logic ev,
                                logic [63:0] epc, logic [31:0] eins);
        vec_t v;
        v.ar_ready = arr; v.r_valid = rvl; v.r_data = rd; v.rdy = rdy;
        v.rv = redv; v.rpc = rpc; v.e_arv = earv; v.e_addr = eaddr;
        v.e_rr = err_; v.e_v = ev; v.e_pc = epc; v.e_ins = eins;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Memory image used by the random slave: every word derived from its address.
    function automatic logic [31:0] mw(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [1:0] mresp(input logic [63:0] a);
        return (a[5:3] == 3'b101) ? 2'b10 : 2'b00;
    endfunction

    localparam logic [63:0] RST = 64'h0000_0000_8000_0000;
    localparam logic [63:0] D1  = 64'h00000013_00100093;
    localparam logic [63:0] D2  = 64'hBBBB_BBBB_AAAA_AAAA;
    localparam logic [63:0] D3  = 64'h2222_2222_1111_1111;
    localparam logic [63:0] D4  = 64'h5555_5555_4444_4444;

    vec_t tbl[24];

    initial begin
        // model / slave state for the random phase
        logic [63:0] model_pc;
        logic        outst;
        logic [63:0] oaddr;
        int          dly;
        int          delivered;
        int          cyc;
        int          waited;
        logic        p_hold, p_hold_redir, p_ar_stall;
        logic [63:0] p_pc, p_addr;
        logic [31:0] p_ins;
        logic        p_err;
        logic        xfer;

        tbl[0]  = mk(1,1,D1,1,0,0,           0,0,0,            0,0,0);
        tbl[1]  = mk(1,1,D1,1,0,0,           1,RST,0,          0,0,0);
        tbl[2]  = mk(1,1,D1,1,0,0,           0,0,1,            0,0,0);
        tbl[3]  = mk(1,1,D1,1,0,0,           0,0,0,            1,RST,32'h00100093);
        tbl[4]  = mk(1,1,D1,0,0,0,           1,RST,0,          0,0,0);
        tbl[5]  = mk(1,1,D1,0,0,0,           0,0,1,            0,0,0);
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(1,1,D1,0,0,0,        0,0,0,            1,RST+4,32'h00000013);
        tbl[11] = mk(1,1,D1,1,0,0,           0,0,0,            1,RST+4,32'h00000013);
        tbl[12] = mk(1,1,D2,1,0,0,           1,RST+8,0,        0,0,0);
        tbl[13] = mk(1,1,D2,1,0,0,           0,0,1,            0,0,0);
        tbl[14] = mk(1,1,D2,1,0,0,           0,0,0,            1,RST+8,32'hAAAA_AAAA);
        tbl[15] = mk(1,1,D2,1,0,0,           1,RST+8,0,        0,0,0);
        tbl[16] = mk(1,1,D2,1,0,0,           0,0,1,            0,0,0);
        tbl[17] = mk(1,1,D2,1,0,0,           0,0,0,            1,RST+12,32'hBBBB_BBBB);
        tbl[18] = mk(1,1,D3,1,0,0,           1,RST+16,0,       0,0,0);
        tbl[19] = mk(1,1,D3,1,0,0,           0,0,1,            0,0,0);
        tbl[20] = mk(1,1,D3,1,1,64'h8000_0103, 0,0,0,          1,RST+16,32'h1111_1111);
        tbl[21] = mk(1,1,D4,1,0,0,           1,64'h8000_0100,0, 0,0,0);
        tbl[22] = mk(1,1,D4,1,0,0,           0,0,1,            0,0,0);
        tbl[23] = mk(1,1,D4,0,0,0,           0,0,0,            1,64'h8000_0100,32'h4444_4444);

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ready_in = 1'b0;
        axi.ar_ready = 1'b0; axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = 2'b00;
        @(negedge clk);
        step(); step();

        // reset values
        chk("rst_ar_valid", axi.ar_valid, 0);
        chk("rst_r_ready", axi.r_ready, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_ins_out", ins_out, 0);
        chk("rst_pc_out", pc_out, RST);
        chk("rst_ar_addr", axi.ar_addr, RST);
        reset = 1'b0;

        // directed table: boot fetch, hold stall, redirect on transfer
        for (int i = 0; i < 24; i++) begin
            axi.ar_ready = tbl[i].ar_ready; axi.r_valid = tbl[i].r_valid;
            axi.r_data = tbl[i].r_data; axi.r_resp = 2'b00;
            ready_in = tbl[i].rdy; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            chk($sformatf("tbl%0d_ar_valid", i), axi.ar_valid, tbl[i].e_arv);
            chk($sformatf("tbl%0d_r_ready", i), axi.r_ready, tbl[i].e_rr);
            chk($sformatf("tbl%0d_valid_out", i), valid_out, tbl[i].e_v);
            if (tbl[i].e_arv) chk($sformatf("tbl%0d_ar_addr", i), axi.ar_addr, tbl[i].e_addr);
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d_pc_out", i), pc_out, tbl[i].e_pc);
                chk($sformatf("tbl%0d_ins_out", i), ins_out, tbl[i].e_ins);
            end
            step();
        end
        redirect_valid = 1'b0;

        // redirect during DATA with late r_valid: returned data must vanish
        ready_in = 1'b1; axi.ar_ready = 1'b1; axi.r_valid = 1'b0;
        step();                 // -> ADDR
        step();                 // -> DATA
        ready_in = 1'b0; axi.ar_ready = 1'b0;
        chk("kill_in_data", axi.r_ready, 1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("kill_wait_valid_out", valid_out, 0);
            step();
        end
        axi.r_valid = 1'b1; axi.r_data = D4;
        step();
        axi.r_valid = 1'b0;
        waited = 0;
        while (!axi.ar_valid && waited < 8) begin
            chk("kill_drop_valid_out", valid_out, 0);
            step();
            waited++;
        end
        chk("kill_ar_seen", axi.ar_valid, 1);
        chk("kill_next_addr", axi.ar_addr, 64'h8000_0200);
        chk("kill_no_valid", valid_out, 0);

        // ar_ready stall, then error response still advances pc
        axi.ar_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("arstall_valid", axi.ar_valid, 1);
            chk("arstall_addr", axi.ar_addr, 64'h8000_0200);
            step();
        end
        axi.ar_ready = 1'b1;
        step();
        axi.ar_ready = 1'b0; axi.r_valid = 1'b1; axi.r_resp = 2'b10;
        axi.r_data = 64'h6666_6666_7777_7777;
        step();
        axi.r_valid = 1'b0; axi.r_resp = 2'b00;
        chk("err_valid_out", valid_out, 1);
        chk("err_fetch_err", fetch_err, 1);
        chk("err_pc_out", pc_out, 64'h8000_0200);
        chk("err_ins_out", ins_out, 32'h7777_7777);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        chk("err_next_ar_valid", axi.ar_valid, 1);
        chk("err_next_addr", axi.ar_addr, 64'h8000_0200);
        axi.ar_ready = 1'b1;
        step();
        axi.ar_ready = 1'b0; axi.r_valid = 1'b1;
        step();
        axi.r_valid = 1'b0;
        chk("err_next_pc_out", pc_out, 64'h8000_0204);
        chk("err_next_ins", ins_out, 32'h6666_6666);
        chk("err_next_ok", fetch_err, 0);

        // reset in the middle of a read, with stale r_valid afterwards
        ready_in = 1'b1; axi.ar_ready = 1'b1;
        step(); step();         // HOLD -> ADDR -> DATA
        ready_in = 1'b0; axi.ar_ready = 1'b0;
        reset = 1'b1; axi.r_valid = 1'b1; axi.r_data = D1;
        step(); step();
        reset = 1'b0;
        chk("midrst_ar_valid", axi.ar_valid, 0);
        chk("midrst_r_ready", axi.r_ready, 0);
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_pc_out", pc_out, RST);
        step();
        chk("midrst_ar_up", axi.ar_valid, 1);
        chk("midrst_addr", axi.ar_addr, RST);
        step();
        chk("midrst_stale_rv", valid_out, 0);
        chk("midrst_stale_rr", axi.r_ready, 0);
        axi.r_valid = 1'b0;

        // randomized traffic vs. program-order model
        model_pc = RST; outst = 1'b0; oaddr = '0; dly = 0; delivered = 0; cyc = 0;
        p_hold = 1'b0; p_hold_redir = 1'b0; p_ar_stall = 1'b0;
        p_pc = '0; p_addr = '0; p_ins = '0; p_err = 1'b0;
        while (delivered < 400 && cyc < 20000) begin
            if (p_hold) begin
                chk("rnd_hold_valid", valid_out, 1);
                chk("rnd_hold_pc", pc_out, p_pc);
                chk("rnd_hold_ins", ins_out, p_ins);
                chk("rnd_hold_err", fetch_err, p_err);
            end
            if (p_hold_redir) chk("rnd_redir_drop", valid_out, 0);
            if (p_ar_stall) begin
                chk("rnd_ar_hold_valid", axi.ar_valid, 1);
                chk("rnd_ar_hold_addr", axi.ar_addr, p_addr);
            end
            chk("rnd_ar_r_exclusive", axi.ar_valid & axi.r_ready, 0);

            axi.ar_ready = ($urandom_range(0, 2) != 0);
            if (outst) begin
                if (dly == 0) begin
                    axi.r_valid = 1'b1;
                    axi.r_data  = {mw(oaddr + 64'd4), mw(oaddr)};
                    axi.r_resp  = mresp(oaddr);
                end else begin
                    axi.r_valid = 1'b0;
                    dly--;
                end
            end else begin
                axi.r_valid = ($urandom_range(0, 7) == 0);
                axi.r_data  = {$urandom, $urandom};
                axi.r_resp  = 2'($urandom_range(0, 3));
            end
            ready_in = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom_range(0, 15))};
            else
                redirect_pc = {32'h0, 20'h80000, 12'($urandom_range(0, 4095))};

            xfer = valid_out & ready_in;
            if (xfer) begin
                chk("rnd_pc_out", pc_out, model_pc);
                chk("rnd_ins_out", ins_out, mw(model_pc));
                chk("rnd_fetch_err", fetch_err, mresp(model_pc) != 2'b00);
                model_pc = model_pc + 64'd4;
                delivered++;
            end
            if (redirect_valid) model_pc = redirect_pc & ~64'd3;
            if (axi.ar_valid && axi.ar_ready) begin
                chk("rnd_single_outstanding", outst, 0);
                chk("rnd_addr_aligned", axi.ar_addr[2:0], 0);
                outst = 1'b1; oaddr = axi.ar_addr; dly = $urandom_range(0, 3);
            end
            if (axi.r_valid && axi.r_ready) begin
                chk("rnd_r_outstanding", outst, 1);
                outst = 1'b0;
            end

            p_hold       = valid_out & ~ready_in & ~redirect_valid;
            p_hold_redir = valid_out & ~ready_in & redirect_valid;
            p_ar_stall   = axi.ar_valid & ~axi.ar_ready;
            p_pc = pc_out; p_ins = ins_out; p_err = fetch_err; p_addr = axi.ar_addr;
            step();
            cyc++;
        end
        chk("rnd_progress", delivered >= 400, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_ifu.md
YSYX_22041071_IFU -- requirements
Module: ysyx_22041071_ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 redirect_valid  input  1  next-PC override; ID asserts it on handshake of a jal/jalr/branch.
REQ-005 redirect_pc  input  64  target PC, sampled when redirect_valid=1.
REQ-006 ar_valid  output  1  AXI read-address valid.
REQ-007 ar_addr  output  64  AXI read address, 8-byte aligned.
REQ-008 ar_ready  input  1  AXI read-address ready.
REQ-009 r_valid  input  1  AXI read-data valid.
REQ-010 r_data  input  64  AXI read data.
REQ-011 r_resp  input  2  AXI response; 2'b00 = OKAY.
REQ-012 r_ready  output  1  AXI read-data ready.
REQ-013 pc_out  output  64  PC of the instruction offered to ID.
REQ-014 ins_out  output  32  instruction offered to ID.
REQ-015 valid_out  output  1  pc_out/ins_out/fetch_err valid.
REQ-016 ready_in  input  1  ID ready; transfer occurs when valid_out & ready_in.
REQ-017 fetch_err  output  1  instruction returned with r_resp != OKAY.

Function
REQ-018 FSM states: IDLE, ADDR, DATA, HOLD; IDLE always advances to ADDR next cycle.
REQ-019 ADDR: ar_valid=1, ar_addr={pc[63:3],3'b000}; address held stable until ar_ready=1, then DATA.
REQ-020 DATA: r_ready=1; on r_valid=1 capture data, go HOLD (or ADDR if kill set, REQ-024).
REQ-021 Capture: ins_out = pc[2] ? r_data[63:32] : r_data[31:0]; pc_out = pc; fetch_err = (r_resp != 2'b00).
REQ-022 HOLD: valid_out=1, outputs stable until ready_in=1; on transfer pc <= pc+4 (or redirect_pc if redirect_valid same cycle), go ADDR directly.
REQ-023 Redirect in HOLD without ready_in: valid_out drops next cycle, pc <= redirect_pc, go ADDR; held instruction discarded.
REQ-024 Redirect in ADDR or DATA: set kill flag, pc <= redirect_pc; AXI transaction completes normally; returned data discarded (no valid_out); kill cleared on discard; next fetch uses new pc.
REQ-025 Redirect in IDLE: pc <= redirect_pc; no kill.
REQ-026 Later redirect while kill already set overwrites pc; latest target wins.
REQ-027 redirect_pc[1:0] forced to 2'b00 on load.
REQ-028 pc+4 wraps modulo 2^64.
REQ-029 Minimum steady-state period with single-cycle AXI responses: 3 cycles/instruction (ADDR, DATA, HOLD).
REQ-030 ar_valid and r_ready never asserted together; at most one read outstanding.
REQ-031 fetch_err does not stall the FSM; pc advances as for OKAY.

Reset
REQ-032 During reset: state=IDLE, pc=RESET_PC, kill=0, ar_valid=0, r_ready=0, valid_out=0, fetch_err=0, ins_out=32'h0, pc_out=RESET_PC, ar_addr=RESET_PC.
REQ-033 Reset mid-transaction abandons it; stale r_valid after reset outside DATA is ignored.

Verification
REQ-034 Reset release, ar_ready=r_valid=1, r_data=64'h00000013_00100093, ready_in=1 -> ar_addr=0x8000_0000 two cycles after release; ins_out=0x00100093, pc_out=0x8000_0000; next ins_out=0x00000013 with pc_out=0x8000_0004, both from the same 8-byte-aligned address.
REQ-035 ready_in=0 for 5 cycles in HOLD -> valid_out, pc_out, ins_out constant; single transfer when ready_in rises.
REQ-036 Transfer at pc 0x8000_0010 with redirect_valid=1, redirect_pc=0x8000_0100 -> next ar_addr=0x8000_0100; no fetch of 0x8000_0014.
REQ-037 redirect_valid pulse in DATA with r_valid delayed 3 cycles -> returned data dropped (valid_out stays 0); next ar_addr = redirect target.
REQ-038 ar_ready low 4 cycles -> ar_valid, ar_addr stable throughout; r_resp=2'b10 -> fetch_err=1 with valid_out; next fetch pc+4.
